// File: rtl/fsm_step_ctrl.sv
// State holder and opcode feeder for the microcoded next-state sequencer.
// Optional STEP_COUNT_EN adds step and stall counters.
module fsm_step_ctrl #(
  parameter int unsigned           DEPTH       = 4,
  parameter int unsigned           STATE_W     = 4,
  parameter logic [STATE_W-1:0]    DISP_A      = STATE_W'(3),
  parameter logic [STATE_W-1:0]    DISP_B      = STATE_W'(10),
  parameter logic [STATE_W-1:0]    RESET_STATE = STATE_W'(0)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               op_in,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [STATE_W-1:0]       final_state,
  output logic [STATE_W-1:0]       current_state,
  output logic [1:0]               y,
  output logic                     stall,
  output logic                     step,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef STEP_COUNT_EN
  ,
  output logic [15:0]              step_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {PRESENT = 1'b0, CAPTURE = 1'b1} phase_e;

  phase_e              phase_q;
  logic [STATE_W-1:0]  state_q;
  logic                step_q;
  logic [1:0]          mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                is_disp_s, empty_s, full_s, stall_s, push_s, pop_s;

  // Stall and FIFO next-state decode
  always_comb begin
    is_disp_s = (state_q == DISP_A) || (state_q == DISP_B);
    empty_s   = (count_q == CW'(0));
    full_s    = (count_q == CW'(DEPTH));
    stall_s   = is_disp_s && empty_s;
    push_s    = op_valid && !full_s;
    pop_s     = (phase_q == CAPTURE) && is_disp_s && !empty_s;
    wr_ptr_d  = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Phase machine: present state, then capture the sequencer's answer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PRESENT;
      state_q <= RESET_STATE;
      step_q  <= 1'b0;
    end else begin
      case (phase_q)
        PRESENT: begin
          step_q <= 1'b0;
          if (!stall_s) phase_q <= CAPTURE;
          else          phase_q <= PRESENT;
        end
        CAPTURE: begin
          state_q <= final_state;
          step_q  <= 1'b1;
          phase_q <= PRESENT;
        end
        default: begin
          step_q  <= 1'b0;
          phase_q <= PRESENT;
        end
      endcase
    end
  end

  // Opcode FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) mem_q[wr_ptr_q] <= op_in;
    end
  end

`ifdef STEP_COUNT_EN
  logic [15:0] step_cnt_q, stall_cnt_q;

  // Step counter wraps; stall counter saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (phase_q == CAPTURE) step_cnt_q <= step_cnt_q + 16'd1;
      if (stall_s && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign step_cnt  = step_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign current_state = state_q;
  assign step          = step_q;
  assign stall         = stall_s;
  assign op_ready      = !full_s;
  assign q_count       = count_q;
  assign y             = empty_s ? 2'b00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Directed bench for fsm_step_ctrl with a small registered sequencer model.
module tb_fsm_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op_in;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] final_state;
  logic [3:0] current_state;
  logic [1:0] y;
  logic       stall;
  logic       step;
  logic [2:0] q_count;
`ifdef STEP_COUNT_EN
  logic [15:0] step_cnt;
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fsm_step_ctrl dut (
    .clk(clk), .reset(reset), .op_in(op_in), .op_valid(op_valid),
    .op_ready(op_ready), .final_state(final_state),
    .current_state(current_state), .y(y), .stall(stall), .step(step),
    .q_count(q_count)
`ifdef STEP_COUNT_EN
    , .step_cnt(step_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Sequencer model: dispatch at 3 goes to 4+y, 10 goes to 11, else increment
  function automatic logic [3:0] seq_next(input logic [3:0] st, input logic [1:0] op);
    if (st == 4'd3)       return 4'd4 + {2'b00, op};
    else if (st == 4'd10) return 4'd11;
    else                  return st + 4'd1;
  endfunction

  always @(posedge clk) final_state <= seq_next(current_state, y);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] ops [4];

  initial begin
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11; ops[3] = 2'b00;
    reset = 1'b1; op_valid = 1'b0; op_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(current_state), 32'd0);
    check("rst_qcnt", 32'(q_count), 32'd0);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_step", 32'(step), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    reset = 1'b0;

    // Free-run up to the first dispatch state with an empty FIFO
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("run_step_lo", 32'(step), 32'd0);
      tick();
      check("run_state", 32'(current_state), 32'(k));
      check("run_step_hi", 32'(step), 32'd1);
    end
    tick();
    check("stall_on", 32'(stall), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_state", 32'(current_state), 32'd3);
      check("stall_step", 32'(step), 32'd0);
      check("stall_hold", 32'(stall), 32'd1);
    end

    // Release the stall with a single opcode
    op_in = 2'b01; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    check("rel_stall", 32'(stall), 32'd0);
    check("rel_y", 32'(y), 32'd1);
    check("rel_qcnt", 32'(q_count), 32'd1);
    tick();
    check("rel_qcnt_p", 32'(q_count), 32'd1);
    check("rel_state_p", 32'(current_state), 32'd3);
    tick();
    check("rel_state", 32'(current_state), 32'd5);
    check("rel_qcnt_c", 32'(q_count), 32'd0);
    check("rel_step", 32'(step), 32'd1);

    // Fill the FIFO while stepping 0 -> 2, then overflow attempt
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_in = ops[i]; op_valid = 1'b1;
      tick();
    end
    check("full_ready", 32'(op_ready), 32'd0);
    check("full_qcnt", 32'(q_count), 32'd4);
    check("full_state", 32'(current_state), 32'd2);
    op_in = 2'b10;
    tick();
    check("ovf_qcnt", 32'(q_count), 32'd4);
    check("ovf_y", 32'(y), 32'd1);
    tick();
    check("full_disp", 32'(current_state), 32'd3);
    check("full_disp_rdy", 32'(op_ready), 32'd0);
    check("full_disp_stall", 32'(stall), 32'd0);
    tick();
    check("full_cap_q", 32'(q_count), 32'd4);
    tick();
    op_valid = 1'b0;
    check("pop_state", 32'(current_state), 32'd5);
    check("pop_qcnt", 32'(q_count), 32'd3);
    check("pop_ready", 32'(op_ready), 32'd1);
    check("pop_y", 32'(y), 32'd2);
    repeat (10) tick();
    check("d10_state", 32'(current_state), 32'd10);
    check("d10_y", 32'(y), 32'd2);
    check("d10_qcnt", 32'(q_count), 32'd3);
    repeat (2) tick();
    check("d10_next", 32'(current_state), 32'd11);
    check("d10_qcnt_after", 32'(q_count), 32'd2);
    check("d10_y_after", 32'(y), 32'd3);

    // Async reset while in CAPTURE with three opcodes queued
    op_in = 2'b01; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    check("pre_rst_qcnt", 32'(q_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(current_state), 32'd0);
    check("mid_rst_qcnt", 32'(q_count), 32'd0);
    check("mid_rst_ready", 32'(op_ready), 32'd1);
    check("mid_rst_step", 32'(step), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_state", 32'(current_state), 32'd0);
    tick();
    check("post_rst_load", 32'(current_state), 32'd1);

    // Eight steps with a five-cycle stall at state 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("cnt_at3", 32'(current_state), 32'd3);
    repeat (4) tick();
    op_in = 2'b01; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    repeat (2) tick();
    check("cnt_at5", 32'(current_state), 32'd5);
    repeat (8) tick();
    check("cnt_at9", 32'(current_state), 32'd9);
`ifdef STEP_COUNT_EN
    check("step_cnt", 32'(step_cnt), 32'd8);
    check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
